branch_predictor: RTL

//  Fetch-stage direction/target predictor: a BHT of 2-bit saturating counters plus a tagged BTB,

---
 rtl/branch_predictor.sv | 80 ++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: BHT of 2-bit counters plus tagged BTB; predicts for IF, trains from EX, flags mispredicts, counts branches
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);
  localparam int N = 1 << IDX_BITS;
  logic [N-1:0][1:0]          ctr_q, ctr_d;
  logic [N-1:0]               valid_q, valid_d;
  logic [N-1:0][TAG_BITS-1:0] tag_q, tag_d;
  logic [N-1:0][31:0]         target_q, target_d;
  logic [31:0]                br_count_q, br_count_d, mispred_count_q, mispred_count_d;
  logic [IDX_BITS-1:0]        if_idx, upd_idx;
  logic [TAG_BITS-1:0]        if_tag, upd_tag;
  logic                       upd_hit;
  logic [1:0]                 ctr_step;
  assign if_idx  = if_pc[IDX_BITS+1:2];
  assign if_tag  = if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign upd_idx = upd_pc[IDX_BITS+1:2];
  assign upd_tag = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;
  always_comb begin
    pred_taken  = !rst && valid_q[if_idx] && tag_q[if_idx] == if_tag && ctr_q[if_idx][1];
    pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;
    mispredict  = !rst && upd_valid &&
                  (upd_pred_taken != upd_taken || (upd_taken && upd_pred_target != upd_target));
    redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;
    upd_hit     = valid_q[upd_idx] && tag_q[upd_idx] == upd_tag;
    ctr_step    = upd_taken ? (ctr_q[upd_idx] == 2'b11 ? 2'b11 : ctr_q[upd_idx] + 2'b01)
                            : (ctr_q[upd_idx] == 2'b00 ? 2'b00 : ctr_q[upd_idx] - 2'b01);
    ctr_d           = ctr_q;
    valid_d         = valid_q;
    tag_d           = tag_q;
    target_d        = target_q;
    br_count_d      = br_count_q + {31'd0, upd_valid};
    mispred_count_d = mispred_count_q + {31'd0, mispredict};
    if (upd_valid && upd_hit) begin
      ctr_d[upd_idx] = ctr_step;
      if (upd_taken) target_d[upd_idx] = upd_target;
    end else if (upd_valid && upd_taken) begin
      valid_d[upd_idx]  = 1'b1;
      tag_d[upd_idx]    = upd_tag;
      target_d[upd_idx] = upd_target;
      ctr_d[upd_idx]    = 2'b10;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr_q           <= {N{2'b01}};
      valid_q         <= '0;
      tag_q           <= '0;
      target_q        <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      ctr_q           <= ctr_d;
      valid_q         <= valid_d;
      tag_q           <= tag_d;
      target_q        <= target_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end
endmodule
